// File: rtl/palette_pkg.sv
// palette_pkg: shared types and helpers for the palette LUT / fader slice.
//   rgb_t        - {red, green, blue} colour word at the default channel width
//   fade_state_t - fade controller states
//   FULL_LEVEL   - full-brightness level at the default channel width
//   scale_ch()   - (c * level) >> ch_w, width-generic up to MAX_CH_W bits
package palette_pkg;

  localparam int unsigned DEF_CH_W   = 4;
  localparam int unsigned MAX_CH_W   = 16;
  localparam int unsigned FULL_LEVEL = 1 << DEF_CH_W;

  typedef struct packed {
    logic [DEF_CH_W-1:0] red;
    logic [DEF_CH_W-1:0] green;
    logic [DEF_CH_W-1:0] blue;
  } rgb_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;

  // Channel scaling; callers zero-extend c/level to MAX_CH_W and slice the
  // low ch_w bits of the result.
  function automatic logic [MAX_CH_W-1:0] scale_ch(
    input logic [MAX_CH_W-1:0] c,
    input logic [MAX_CH_W:0]   level,
    input int unsigned         ch_w
  );
    logic [2*MAX_CH_W:0] p;
    p = {{MAX_CH_W{1'b0}}, 1'b0, c} * {{MAX_CH_W{1'b0}}, level};
    p = p >> ch_w;
    return p[MAX_CH_W-1:0];
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl: frame-synchronous fade-to/from-black brightness engine.
//   Clk, Reset   - clock, async active-high reset
//   frame_tick   - one pulse per frame; level only changes on this pulse
//   fade_start   - begin a fade (ignored while fading)
//   fade_dir     - 0 = fade out to 0, 1 = fade in to 2^CH_W
//   level        - current brightness, 0..2^CH_W
//   fade_busy    - high while FADING
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int unsigned CH_W = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_tick,
  input  logic          fade_start,
  input  logic          fade_dir,
  output logic [CH_W:0] level,
  output logic          fade_busy
);

  localparam logic [CH_W:0] FULL = {1'b1, {CH_W{1'b0}}};

  fade_state_t   state_q, state_d;
  logic          dir_q, dir_d;
  logic [CH_W:0] level_q, level_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        if (fade_start) begin
          state_d = FADING;
          dir_d   = fade_dir;
        end
      end
      FADING: begin
        // Saturating step; reaching (or already sitting at) the target ends the fade.
        if (frame_tick) begin
          if (!dir_q) begin
            if (level_q != '0) level_d = level_q - 1'b1;
            if (level_q <= 1)  state_d = IDLE;
          end else begin
            if (level_q != FULL)        level_d = level_q + 1'b1;
            if (level_q >= FULL - 1'b1) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      level_q <= FULL;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      level_q <= level_d;
    end
  end

  assign level     = level_q;
  assign fade_busy = (state_q == FADING);

endmodule

// File: rtl/palette_lut_fader.sv
// palette_lut_fader: NUM_PAL writable palettes of 2^IDX_W RGB entries, a
// 2-stage index->RGB pipeline and a frame-synchronous brightness fader.
//   Clk, Reset                   - clock, async active-high reset
//   pix_valid_in/pix_index/pal_sel - pixel lookup request
//   wr_en/wr_pal/wr_addr/wr_rgb  - palette entry write port
//   frame_tick/fade_start/fade_dir - fade control; fade_busy while fading
//   pix_valid_out, red/green/blue - scaled colour, blanked when not valid
//   transparent                  - only with PALETTE_TRANSPARENCY_EN: index was 0
module palette_lut_fader
  import palette_pkg::*;
#(
  parameter  int unsigned IDX_W   = 4,
  parameter  int unsigned NUM_PAL = 4,
  parameter  int unsigned CH_W    = 4,
  localparam int unsigned PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid_in,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic [PAL_W-1:0]  pal_sel,
  input  logic              wr_en,
  input  logic [PAL_W-1:0]  wr_pal,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              frame_tick,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              fade_busy,
`ifdef PALETTE_TRANSPARENCY_EN
  output logic              transparent,
`endif
  output logic              pix_valid_out,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue
);

  localparam int unsigned   RGB_W   = 3 * CH_W;
  localparam int unsigned   DEPTH   = 1 << (PAL_W + IDX_W);
  localparam logic [PAL_W:0] NPAL_V = NUM_PAL[PAL_W:0];

  logic [RGB_W-1:0] mem [DEPTH];
  logic [RGB_W-1:0] rd_q;
  logic             valid_s1_q, valid_s2_q;
  logic [CH_W-1:0]  red_q, green_q, blue_q;
  logic [CH_W-1:0]  red_d, green_d, blue_d;
  logic [CH_W:0]    level;

  logic rd_ok, wr_ok;
  assign rd_ok = ({1'b0, pal_sel} < NPAL_V);
  assign wr_ok = ({1'b0, wr_pal} < NPAL_V);

  palette_fade_ctrl #(.CH_W(CH_W)) u_fade (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .level      (level),
    .fade_busy  (fade_busy)
  );

  // Storage and stage-1 read data are not reset; the non-blocking read of
  // mem gives read-before-write on a same-address collision.
  always_ff @(posedge Clk) begin
    if (wr_en && wr_ok) mem[{wr_pal, wr_addr}] <= wr_rgb;
    rd_q <= rd_ok ? mem[{pal_sel, pix_index}] : '0;
  end

  always_comb begin
    logic [MAX_CH_W-1:0] r_w, g_w, b_w;
    r_w     = scale_ch(MAX_CH_W'(rd_q[3*CH_W-1:2*CH_W]), (MAX_CH_W+1)'(level), CH_W);
    g_w     = scale_ch(MAX_CH_W'(rd_q[2*CH_W-1:CH_W]),   (MAX_CH_W+1)'(level), CH_W);
    b_w     = scale_ch(MAX_CH_W'(rd_q[CH_W-1:0]),        (MAX_CH_W+1)'(level), CH_W);
    red_d   = r_w[CH_W-1:0];
    green_d = g_w[CH_W-1:0];
    blue_d  = b_w[CH_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      valid_s1_q <= pix_valid_in;
      valid_s2_q <= valid_s1_q;
      red_q      <= valid_s1_q ? red_d   : '0;
      green_q    <= valid_s1_q ? green_d : '0;
      blue_q     <= valid_s1_q ? blue_d  : '0;
    end
  end

`ifdef PALETTE_TRANSPARENCY_EN
  logic idx0_s1_q, transp_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx0_s1_q <= 1'b0;
      transp_q  <= 1'b0;
    end else begin
      idx0_s1_q <= (pix_index == '0);
      transp_q  <= valid_s1_q && idx0_s1_q;
    end
  end
  assign transparent = transp_q;
`endif

  assign pix_valid_out = valid_s2_q;
  assign red           = red_q;
  assign green         = green_q;
  assign blue          = blue_q;

endmodule

// File: tb/tb_palette_lut_fader.sv
module tb_palette_lut_fader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid_in = 1'b0;
  logic [3:0]  pix_index = '0;
  logic [1:0]  pal_sel = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_rgb = '0;
  logic        frame_tick = 1'b0;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic        fade_busy;
  logic        pix_valid_out;
  logic [3:0]  red, green, blue;
`ifdef PALETTE_TRANSPARENCY_EN
  logic        transparent;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  palette_lut_fader #(.IDX_W(4), .NUM_PAL(4), .CH_W(4)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .pix_valid_in  (pix_valid_in),
    .pix_index     (pix_index),
    .pal_sel       (pal_sel),
    .wr_en         (wr_en),
    .wr_pal        (wr_pal),
    .wr_addr       (wr_addr),
    .wr_rgb        (wr_rgb),
    .frame_tick    (frame_tick),
    .fade_start    (fade_start),
    .fade_dir      (fade_dir),
    .fade_busy     (fade_busy),
`ifdef PALETTE_TRANSPARENCY_EN
    .transparent   (transparent),
`endif
    .pix_valid_out (pix_valid_out),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {valid, r, g, b} compared as one 13-bit word
  task automatic chk_pix(input string tag, input logic [12:0] exp);
    chk(tag, {19'd0, pix_valid_out, red, green, blue}, {19'd0, exp});
  endtask

  task automatic wr(input logic [1:0] p, input logic [3:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_pal = p; wr_addr = a; wr_rgb = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] p, input logic [3:0] i);
    pix_valid_in = 1'b1; pal_sel = p; pix_index = i;
    step();
    pix_valid_in = 1'b0;
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  function automatic logic [11:0] pattern(input int unsigned i);
    logic [3:0] a;
    a = 4'(i);
    return {a, 4'(15 - i), a ^ 4'h5};
  endfunction

  initial begin
    // reset state
    step(); step();
    chk_pix("reset_pix", 13'h0000);
    chk("reset_busy", {31'd0, fade_busy}, 32'd0);
    Reset = 1'b0;
    step();

    // basic write/read, 2-cycle latency
    wr(2'd1, 4'd3, 12'h8D0);
    pix_valid_in = 1'b1; pal_sel = 2'd1; pix_index = 4'd3;
    step();
    pix_valid_in = 1'b0;
    chk_pix("lat_1cyc", 13'h0000);
    step();
    chk_pix("basic_8D0", 13'h18D0);
    step();
    chk_pix("blank_after", 13'h0000);

    // read-before-write collision
    wr(2'd0, 4'd5, 12'h000);
    wr_en = 1'b1; wr_pal = 2'd0; wr_addr = 4'd5; wr_rgb = 12'hFFF;
    pix_valid_in = 1'b1; pal_sel = 2'd0; pix_index = 4'd5;
    step();
    wr_en = 1'b0;
    step();
    chk_pix("collide_old", 13'h1000);
    pix_valid_in = 1'b0;
    step();
    chk_pix("collide_new", 13'h1FFF);

    // 16-pixel back-to-back stream
    for (int i = 0; i < 16; i++) wr(2'd2, 4'(i), pattern(i));
    for (int i = 0; i < 16; i++) begin
      pix_valid_in = 1'b1; pal_sel = 2'd2; pix_index = 4'(i);
      step();
      if (i >= 1) chk_pix($sformatf("stream_%0d", i - 1), {1'b1, pattern(i - 1)});
    end
    pix_valid_in = 1'b0;
    step();
    chk_pix("stream_15", {1'b1, pattern(15)});
    step();
    chk_pix("stream_end", 13'h0000);

    // fade out: 16 -> 0, with a stray fade_start(dir=1) mid-fade
    fade_dir = 1'b0; fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    chk("fade_busy_on", {31'd0, fade_busy}, 32'd1);
    for (int t = 0; t < 3; t++) tick();
    fade_dir = 1'b1; fade_start = 1'b1;
    step();
    fade_start = 1'b0; fade_dir = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    rd(2'd1, 4'd3);
    chk_pix("fade_lvl8", 13'h1460);
    for (int t = 0; t < 7; t++) tick();
    chk("busy_tick15", {31'd0, fade_busy}, 32'd1);
    tick();
    chk("busy_tick16", {31'd0, fade_busy}, 32'd0);
    rd(2'd1, 4'd3);
    chk_pix("fade_lvl0", 13'h1000);
    tick();
    rd(2'd1, 4'd3);
    chk_pix("fade_no_wrap", 13'h1000);

    // fade in; start coincides with a tick, which must not count
    fade_dir = 1'b1; fade_start = 1'b1; frame_tick = 1'b1;
    step();
    fade_start = 1'b0; frame_tick = 1'b0;
    step();
    for (int t = 0; t < 4; t++) tick();
    rd(2'd1, 4'd3);
    chk_pix("fadein_lvl4", 13'h1230);
    for (int t = 0; t < 12; t++) tick();
    chk("fadein_done", {31'd0, fade_busy}, 32'd0);
    rd(2'd1, 4'd3);
    chk_pix("fadein_full", 13'h18D0);

    // fade_start with level already at target
    fade_dir = 1'b1; fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    chk("at_target_busy", {31'd0, fade_busy}, 32'd1);
    tick();
    chk("at_target_idle", {31'd0, fade_busy}, 32'd0);
    rd(2'd1, 4'd3);
    chk_pix("at_target_lvl", 13'h18D0);

    // fade out to level 5, then reset mid-fade and mid-pipeline
    fade_dir = 1'b0; fade_start = 1'b1;
    step();
    fade_start = 1'b0;
    for (int t = 0; t < 11; t++) tick();
    rd(2'd1, 4'd3);
    chk_pix("fade_lvl5", 13'h1240);
    pix_valid_in = 1'b1; pal_sel = 2'd1; pix_index = 4'd3;
    step();
    pix_valid_in = 1'b0;
    Reset = 1'b1;
    #2;
    chk("rst_busy", {31'd0, fade_busy}, 32'd0);
    step();
    Reset = 1'b0;
    chk_pix("rst_drop", 13'h0000);
    step();
    chk_pix("rst_drop2", 13'h0000);
    rd(2'd1, 4'd3);
    chk_pix("rst_full", 13'h18D0);

`ifdef PALETTE_TRANSPARENCY_EN
    wr(2'd3, 4'd0, 12'h8D0);
    rd(2'd3, 4'd0);
    chk("transp_idx0", {31'd0, transparent}, 32'd1);
    chk_pix("transp_rgb", 13'h18D0);
    rd(2'd3, 4'd1);
    chk("transp_idx1", {31'd0, transparent}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
